decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I/RV64I decode stage that sits between fetch and execute. It accepts one instruction plus its PC per valid/ready handshake and decodes the full base integer opcode set: LOAD, STORE, OP, OP-IMM, BRANCH, JAL, JALR, LUI and AUIPC. Results are presented one cycle later through a two-entry skid buffer, so backpressure from execute never drops or duplicates an instruction. A synchronous flush discards everything in flight after a taken branch or jump.

## Interface
- XLEN, 32, datapath width; legal values 32 and 64. Sets the widths of pc and immediate and the shamt field width (5 or 6 bits).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of both buffer entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; equals !skid_valid.
- instruction  in  32  raw instruction.
- pc_in  in  XLEN  PC of the instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- pc_out  out  XLEN  PC of the presented bundle.
- rs1, rs2, rd  out  5  register indices.
- immediate  out  XLEN  sign-extended I/S/B/U/J immediate, or zero-extended shamt.
- alu_op  out  4  ALU operation code from the shared constants.
- alu_use_rs2  out  1  ALU operand B is rs2 rather than the immediate.
- alu_use_pc  out  1  ALU operand A is the PC (AUIPC, JAL).
- reg_write, mem_read, mem_write  out  1  write-back and memory controls.
- mem_op_length  out  3  funct3 for LOAD/STORE, 0 otherwise.
- branch  out  1  conditional branch; compare function in branch_cond.
- branch_cond  out  3  funct3 for BRANCH, 0 otherwise.
- jump  out  1  JAL or JALR.
- illegal  out  1  unknown opcode or bad funct field.

## Operation
- Operand A and alu_op per opcode:
  - LOAD, STORE, JALR, AUIPC, LUI: ALU_ADD_OP. LUI forces rs1 to 0.
  - OP: {instruction[30], funct3}.
  - OP-IMM: {1'b0, funct3}, except SRLI/SRAI, which use {instruction[30], 3'b101}.
  - BRANCH: ALU_SUB_OP.
  - JAL: ADD with alu_use_pc=1.
- Immediate formats, all sign-extended from bit 31 to XLEN:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC, as imm[31:12]<<12.
  - J: JAL.
  - Shifts: immediate = zero-extended instruction[20+:log2(XLEN)].
- reg_write=1 for LOAD, OP, OP-IMM, JAL, JALR, LUI, AUIPC, and only when rd≠0 is not required (x0 writes are allowed).
- illegal=1 for any of:
  - an unknown opcode;
  - instruction[1:0]≠2'b11;
  - SLLI/SRLI/SRAI with funct7 other than 0000000/0100000 (with XLEN=32, instruction[25]=1 is also illegal);
  - branch funct3 of 010 or 011.
- When illegal=1, all write/read/branch/jump controls are 0 and the bundle is still delivered with out_valid.

## Timing
- Reset: out_valid=0, skid_valid=0, in_ready=1. All bundle registers clear to 0, including pc_out, immediate and illegal.
- Latency: an instruction accepted at edge N appears at out_valid after edge N when the output register is empty or draining.
- Output register load: when out_valid=0, or out_valid&out_ready, the output register loads from the skid entry if one is valid, otherwise from the input.
- Skid entry: captures the input when in_valid&in_ready while the output register is held (out_valid & !out_ready).
- Ordering: strictly FIFO, at most 2 entries, throughput 1 per cycle when out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, every output is held stable.
- Flush: at the next edge out_valid=0 and skid_valid=0. An input handshake in the same cycle is discarded, so flush overrides in_valid. in_ready=1 in the following cycle.
- Reset overrides flush. Reset mid-stream discards both entries.

## Structure
- Shared constants header holds:
  - opcode constants: LOAD_OP, STORE_OP, REG_OP, IMM_OP, BRANCH_OP, JAL_OP, JALR_OP, LUI_OP, AUIPC_OP;
  - ALU_*_OP codes.
- One combinational sub-module, decode_fields (parameter XLEN), maps instruction to the bundle. decode_stage instantiates it once on the input path and registers the result. The skid stores decoded bundles, not raw instructions.

## Test plan
- Decode addi x1,x2,-1 (0xFFF10093), XLEN=32:
  - rd=1, rs1=2, immediate=0xFFFFFFFF, alu_op=0, reg_write=1, alu_use_rs2=0;
  - out_valid one cycle after accept.
- Decode sw x5,8(x6) (0x00532423): rs1=6, rs2=5, immediate=8, mem_write=1, mem_op_length=3'b010, reg_write=0.
- Decode beq x0,x0,-4 (0xFE000EE3): branch=1, branch_cond=0, immediate=0xFFFFFFFC, alu_op=ALU_SUB_OP.
- Decode srai x1,x1,3 (0x4030D093): alu_op=4'b1101, immediate=3. Decode 0x00000000: illegal=1, all controls 0.
- Backpressure: hold out_ready=0 and offer instructions A, B, C back-to-back.
  - in_ready falls after B is accepted and C is held at the input.
  - Then set out_ready=1: A, B, C emerge in order on consecutive cycles, with no loss.
- Flush while both entries are full and in_valid=1: next cycle out_valid=0, in_ready=1, and none of the three instructions ever appears. The same sequence with reset yields the reset values listed under Timing.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode and ALU constants plus the decoded control bundle shared by the decode stage
package decode_stage_pkg;
  localparam logic [6:0] LOAD_OP   = 7'b0000011;
  localparam logic [6:0] STORE_OP  = 7'b0100011;
  localparam logic [6:0] REG_OP    = 7'b0110011;
  localparam logic [6:0] IMM_OP    = 7'b0010011;
  localparam logic [6:0] BRANCH_OP = 7'b1100011;
  localparam logic [6:0] JAL_OP    = 7'b1101111;
  localparam logic [6:0] JALR_OP   = 7'b1100111;
  localparam logic [6:0] LUI_OP    = 7'b0110111;
  localparam logic [6:0] AUIPC_OP  = 7'b0010111;
  localparam logic [3:0] ALU_ADD_OP  = 4'b0000;
  localparam logic [3:0] ALU_SLL_OP  = 4'b0001;
  localparam logic [3:0] ALU_SLT_OP  = 4'b0010;
  localparam logic [3:0] ALU_SLTU_OP = 4'b0011;
  localparam logic [3:0] ALU_XOR_OP  = 4'b0100;
  localparam logic [3:0] ALU_SRL_OP  = 4'b0101;
  localparam logic [3:0] ALU_OR_OP   = 4'b0110;
  localparam logic [3:0] ALU_AND_OP  = 4'b0111;
  localparam logic [3:0] ALU_SUB_OP  = 4'b1000;
  localparam logic [3:0] ALU_SRA_OP  = 4'b1101;
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       alu_use_rs2;
    logic       alu_use_pc;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_op_length;
    logic       branch;
    logic [2:0] branch_cond;
    logic       jump;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side handshake and execute-side decoded bundle.
// slave modport is the decode stage's view, master is the surrounding pipeline's view.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] immediate;
  logic [3:0]      alu_op;
  logic            alu_use_rs2;
  logic            alu_use_pc;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      mem_op_length;
  logic            branch;
  logic [2:0]      branch_cond;
  logic            jump;
  logic            illegal;
  modport slave (
    input  in_valid, instruction, pc_in, out_ready,
    output in_ready, out_valid, pc_out, rs1, rs2, rd, immediate, alu_op, alu_use_rs2, alu_use_pc,
           reg_write, mem_read, mem_write, mem_op_length, branch, branch_cond, jump, illegal
  );
  modport master (
    output in_valid, instruction, pc_in, out_ready,
    input  in_ready, out_valid, pc_out, rs1, rs2, rd, immediate, alu_op, alu_use_rs2, alu_use_pc,
           reg_write, mem_read, mem_write, mem_op_length, branch, branch_cond, jump, illegal
  );
endinterface

// File: rtl/decode_fields.sv
// decode_fields: combinational RV32I/RV64I decoder.
// Ports: instruction (raw 32-bit word) -> ctrl (control bundle), immediate (XLEN-wide operand).
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] immediate
);
  localparam int SW = (XLEN == 64) ? 6 : 5;
  logic [6:0] opc;
  logic [2:0] f3;
  logic is_load, is_store, is_reg, is_imm, is_branch, is_jal, is_jalr, is_lui, is_auipc;
  logic is_shift, bad_shift, bad_branch, illegal;
  assign opc       = instruction[6:0];
  assign f3        = instruction[14:12];
  assign is_load   = opc == LOAD_OP;
  assign is_store  = opc == STORE_OP;
  assign is_reg    = opc == REG_OP;
  assign is_imm    = opc == IMM_OP;
  assign is_branch = opc == BRANCH_OP;
  assign is_jal    = opc == JAL_OP;
  assign is_jalr   = opc == JALR_OP;
  assign is_lui    = opc == LUI_OP;
  assign is_auipc  = opc == AUIPC_OP;
  assign is_shift  = is_imm && (f3 == 3'b001 || f3 == 3'b101);
  // bit 30 selects logical/arithmetic; every other funct7 bit above the shamt must be zero
  assign bad_shift  = is_shift && ({instruction[31], instruction[29:26]} != 5'd0 || (XLEN == 32 && instruction[25]));
  assign bad_branch = is_branch && f3[2:1] == 2'b01;
  assign illegal    = !(is_load || is_store || is_reg || is_imm || is_branch || is_jal || is_jalr || is_lui || is_auipc)
                      || instruction[1:0] != 2'b11 || bad_shift || bad_branch;
  always_comb begin
    ctrl               = '0;
    ctrl.rs1           = is_lui ? 5'd0 : instruction[19:15];
    ctrl.rs2           = instruction[24:20];
    ctrl.rd            = instruction[11:7];
    ctrl.alu_op        = is_reg ? {instruction[30], f3} :
                         is_imm ? (f3 == 3'b101 ? {instruction[30], 3'b101} : {1'b0, f3}) :
                         is_branch ? ALU_SUB_OP : ALU_ADD_OP;
    ctrl.alu_use_rs2   = is_reg || is_branch;
    ctrl.alu_use_pc    = is_auipc || is_jal;
    ctrl.reg_write     = !illegal && (is_load || is_reg || is_imm || is_jal || is_jalr || is_lui || is_auipc);
    ctrl.mem_read      = !illegal && is_load;
    ctrl.mem_write     = !illegal && is_store;
    ctrl.mem_op_length = (is_load || is_store) ? f3 : 3'b000;
    ctrl.branch        = !illegal && is_branch;
    ctrl.branch_cond   = is_branch ? f3 : 3'b000;
    ctrl.jump          = !illegal && (is_jal || is_jalr);
    ctrl.illegal       = illegal;
    immediate          = is_store ? XLEN'($signed({instruction[31:25], instruction[11:7]})) :
                         is_branch ? XLEN'($signed({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0})) :
                         (is_lui || is_auipc) ? XLEN'($signed({instruction[31:12], 12'b0})) :
                         is_jal ? XLEN'($signed({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0})) :
                         is_shift ? XLEN'(instruction[20 +: SW]) :
                         (is_load || is_imm || is_jalr) ? XLEN'($signed(instruction[31:20])) : '0;
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode stage with a two-entry skid buffer between fetch and execute.
// Ports: clk, reset (sync, active-high), flush (sync discard of both entries), bus (decode_stage_if slave).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  decode_stage_if.slave  bus
);
  ctrl_t           dec_ctrl, out_ctrl, skid_ctrl;
  logic [XLEN-1:0] dec_imm, out_imm, skid_imm, out_pc, skid_pc;
  logic            out_valid, skid_valid, accept, load_out;
  decode_fields #(.XLEN(XLEN)) u_fields (
    .instruction(bus.instruction),
    .ctrl       (dec_ctrl),
    .immediate  (dec_imm)
  );
  assign accept   = bus.in_valid && !skid_valid;
  assign load_out = !out_valid || bus.out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_ctrl   <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
      skid_ctrl  <= '0;
      skid_imm   <= '0;
      skid_pc    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      // a full skid blocks in_ready, so it and a new input never compete
      out_valid  <= skid_valid || accept;
      skid_valid <= 1'b0;
      if (skid_valid) begin
        out_ctrl <= skid_ctrl;
        out_imm  <= skid_imm;
        out_pc   <= skid_pc;
      end else if (accept) begin
        out_ctrl <= dec_ctrl;
        out_imm  <= dec_imm;
        out_pc   <= bus.pc_in;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= dec_ctrl;
      skid_imm   <= dec_imm;
      skid_pc    <= bus.pc_in;
    end
  end
  assign bus.in_ready      = !skid_valid;
  assign bus.out_valid     = out_valid;
  assign bus.pc_out        = out_pc;
  assign bus.immediate     = out_imm;
  assign bus.rs1           = out_ctrl.rs1;
  assign bus.rs2           = out_ctrl.rs2;
  assign bus.rd            = out_ctrl.rd;
  assign bus.alu_op        = out_ctrl.alu_op;
  assign bus.alu_use_rs2   = out_ctrl.alu_use_rs2;
  assign bus.alu_use_pc    = out_ctrl.alu_use_pc;
  assign bus.reg_write     = out_ctrl.reg_write;
  assign bus.mem_read      = out_ctrl.mem_read;
  assign bus.mem_write     = out_ctrl.mem_write;
  assign bus.mem_op_length = out_ctrl.mem_op_length;
  assign bus.branch        = out_ctrl.branch;
  assign bus.branch_cond   = out_ctrl.branch_cond;
  assign bus.jump          = out_ctrl.jump;
  assign bus.illegal       = out_ctrl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (XLEN=32)
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int errors = 0;
  int checks = 0;
  decode_stage_if #(.XLEN(32)) bus();
  decode_stage #(.XLEN(32)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = v;
    bus.instruction = ins;
    bus.pc_in = pc;
  endtask
  // single accepted transfer, then sample at the following falling edge
  task automatic send_one(input logic [31:0] ins);
    @(negedge clk);
    drive(1'b1, ins, 32'h200);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL pre_valid got %0b exp 0", bus.out_valid); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
  endtask
  task automatic test_reset;
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.pc_out !== 32'h0 || bus.immediate !== 32'h0) begin errors++; $display("FAIL reset_bundle pc %0h imm %0h exp 0", bus.pc_out, bus.immediate); end
    checks++; if (bus.illegal !== 1'b0 || bus.reg_write !== 1'b0) begin errors++; $display("FAIL reset_ctrl illegal %0b reg_write %0b exp 0", bus.illegal, bus.reg_write); end
  endtask
  task automatic test_addi;
    send_one(32'hFFF10093);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %0b exp 1", bus.out_valid); end
    checks++; if (bus.rd !== 5'd1 || bus.rs1 !== 5'd2) begin errors++; $display("FAIL addi_regs rd %0d rs1 %0d exp 1 2", bus.rd, bus.rs1); end
    checks++; if (bus.immediate !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm got %0h exp ffffffff", bus.immediate); end
    checks++; if (bus.alu_op !== 4'd0 || bus.reg_write !== 1'b1 || bus.alu_use_rs2 !== 1'b0) begin errors++; $display("FAIL addi_ctrl alu %0h rw %0b rs2 %0b exp 0 1 0", bus.alu_op, bus.reg_write, bus.alu_use_rs2); end
    checks++; if (bus.pc_out !== 32'h200) begin errors++; $display("FAIL addi_pc got %0h exp 200", bus.pc_out); end
  endtask
  task automatic test_sw;
    send_one(32'h00532423);
    checks++; if (bus.rs1 !== 5'd6 || bus.rs2 !== 5'd5) begin errors++; $display("FAIL sw_regs rs1 %0d rs2 %0d exp 6 5", bus.rs1, bus.rs2); end
    checks++; if (bus.immediate !== 32'd8) begin errors++; $display("FAIL sw_imm got %0h exp 8", bus.immediate); end
    checks++; if (bus.mem_write !== 1'b1 || bus.mem_op_length !== 3'b010 || bus.reg_write !== 1'b0 || bus.mem_read !== 1'b0) begin errors++; $display("FAIL sw_ctrl mw %0b len %0b rw %0b mr %0b exp 1 010 0 0", bus.mem_write, bus.mem_op_length, bus.reg_write, bus.mem_read); end
  endtask
  task automatic test_beq;
    send_one(32'hFE000EE3);
    checks++; if (bus.branch !== 1'b1 || bus.branch_cond !== 3'd0 || bus.jump !== 1'b0) begin errors++; $display("FAIL beq_ctrl br %0b cond %0d jump %0b exp 1 0 0", bus.branch, bus.branch_cond, bus.jump); end
    checks++; if (bus.immediate !== 32'hFFFFFFFC) begin errors++; $display("FAIL beq_imm got %0h exp fffffffc", bus.immediate); end
    checks++; if (bus.alu_op !== 4'b1000 || bus.alu_use_rs2 !== 1'b1) begin errors++; $display("FAIL beq_alu op %0b rs2 %0b exp 1000 1", bus.alu_op, bus.alu_use_rs2); end
  endtask
  task automatic test_srai;
    send_one(32'h4030D093);
    checks++; if (bus.alu_op !== 4'b1101 || bus.immediate !== 32'd3 || bus.illegal !== 1'b0) begin errors++; $display("FAIL srai alu %0b imm %0h ill %0b exp 1101 3 0", bus.alu_op, bus.immediate, bus.illegal); end
  endtask
  task automatic test_lui;
    send_one(32'h123450B7);
    checks++; if (bus.immediate !== 32'h12345000 || bus.rs1 !== 5'd0 || bus.rd !== 5'd1) begin errors++; $display("FAIL lui imm %0h rs1 %0d rd %0d exp 12345000 0 1", bus.immediate, bus.rs1, bus.rd); end
    checks++; if (bus.reg_write !== 1'b1 || bus.alu_use_pc !== 1'b0 || bus.alu_op !== 4'd0) begin errors++; $display("FAIL lui_ctrl rw %0b pc %0b alu %0h exp 1 0 0", bus.reg_write, bus.alu_use_pc, bus.alu_op); end
  endtask
  task automatic test_illegal;
    logic [31:0] vec [4] = '{32'h00000000, 32'hFE002EE3, 32'h02009093, 32'hFFF10090};
    for (int i = 0; i < 4; i++) begin
      send_one(vec[i]);
      checks++; if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal_%0d valid %0b ill %0b exp 1 1", i, bus.out_valid, bus.illegal); end
      checks++; if ({bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump} !== 5'b0) begin errors++; $display("FAIL illegal_ctrl_%0d got %b exp 00000", i, {bus.reg_write, bus.mem_read, bus.mem_write, bus.branch, bus.jump}); end
    end
  endtask
  // leaves A in the output register, B in the skid, C waiting at the input
  task automatic fill_three;
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hFFF10093, 32'h100);
    @(negedge clk);
    drive(1'b1, 32'h00532423, 32'h104);
    @(negedge clk);
    drive(1'b1, 32'hFE000EE3, 32'h108);
  endtask
  task automatic test_back_to_back;
    fill_three;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.pc_out !== 32'h100) begin errors++; $display("FAIL bp_full ready %0b valid %0b pc %0h exp 0 1 100", bus.in_ready, bus.out_valid, bus.pc_out); end
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h100 || bus.rd !== 5'd1 || bus.immediate !== 32'hFFFFFFFF) begin errors++; $display("FAIL bp_hold pc %0h rd %0d imm %0h exp 100 1 ffffffff", bus.pc_out, bus.rd, bus.immediate); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h104 || bus.mem_write !== 1'b1) begin errors++; $display("FAIL bp_b valid %0b pc %0h mw %0b exp 1 104 1", bus.out_valid, bus.pc_out, bus.mem_write); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready got %0b exp 1", bus.in_ready); end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (bus.out_valid !== 1'b1 || bus.pc_out !== 32'h108 || bus.branch !== 1'b1) begin errors++; $display("FAIL bp_c valid %0b pc %0h br %0b exp 1 108 1", bus.out_valid, bus.pc_out, bus.branch); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", bus.out_valid); end
  endtask
  task automatic test_flush;
    fill_three;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush valid %0b ready %0b exp 0 1", bus.out_valid, bus.in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_%0d valid %0b pc %0h exp 0", i, bus.out_valid, bus.pc_out); end
    end
    // an input handshake offered during flush must be dropped
    drive(1'b1, 32'h4030D093, 32'h300);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_input valid %0b pc %0h exp 0", bus.out_valid, bus.pc_out); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_input_late valid %0b exp 0", bus.out_valid); end
  endtask
  task automatic test_reset_midstream;
    fill_three;
    reset = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mreset valid %0b ready %0b exp 0 1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.pc_out !== 32'h0 || bus.immediate !== 32'h0 || bus.rd !== 5'd0) begin errors++; $display("FAIL mreset_bundle pc %0h imm %0h rd %0d exp 0", bus.pc_out, bus.immediate, bus.rd); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mreset_after valid %0b exp 0", bus.out_valid); end
  endtask
  initial begin
    test_reset;
    test_addi;
    test_sw;
    test_beq;
    test_srai;
    test_lui;
    test_illegal;
    test_back_to_back;
    test_flush;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
